demux_route_ctrl: RTL

- Upstream sequencer for the 1:8 demultiplexer stage.
- Accepts framed words on a valid/ready stream. The header word carries the destination channel and the payload length.
- Each payload word is serialised LSB-first onto a single bit line. A registered channel select is held for the whole frame.
- `bit_out` and `sel_out` drive the demux data and select inputs directly.

---
 rtl/demux_route_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/demux_route_ctrl.sv
// Frame sequencer for the 1:8 demux: header selects a channel, payload words go out LSB-first on one bit line.
// Optional header parity check is enabled by defining DEMUX_ROUTE_PARITY_EN.
module demux_route_ctrl #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 3,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [CH_W-1:0]   sel_out,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              hdr_err
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_DATA, SHIFT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LEN_W:0]    remaining;
    logic              discard;
    logic              xfer;
    logic              hdr_ok;

`ifdef DEMUX_ROUTE_PARITY_EN
    assign hdr_ok = ~(^s_data);
`else
    assign hdr_ok = 1'b1;
`endif

    assign s_ready = (state == IDLE) || (state == WAIT_DATA);
    assign busy    = (state != IDLE);
    assign xfer    = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_out    <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            remaining  <= '0;
            discard    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        // One extra bit so a full-scale length field (2^LEN_W words) fits
                        remaining <= {1'b0, s_data[CH_W+LEN_W-1:CH_W]} + (LEN_W+1)'(1);
                        discard   <= ~hdr_ok;
                        state     <= WAIT_DATA;
                        if (hdr_ok) begin
                            sel_out <= s_data[CH_W-1:0];
                        end else begin
                            hdr_err <= 1'b1;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (xfer) begin
                        if (discard) begin
                            remaining <= remaining - (LEN_W+1)'(1);
                            if (remaining == (LEN_W+1)'(1)) begin
                                discard <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            // Bit 0 goes out on the transfer edge so it is visible the very next cycle
                            bit_out   <= s_data[0];
                            bit_valid <= 1'b1;
                            shift     <= s_data >> 1;
                            bit_cnt   <= CNT_W'(DATA_W - 1);
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (bit_cnt != '0) begin
                        bit_out <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b0;
                        remaining <= remaining - (LEN_W+1)'(1);
                        if (remaining == (LEN_W+1)'(1)) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
